conv3x3_stream: RTL

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

---
 rtl/conv_pkg.sv | 24 ++
 rtl/line_buffer.sv | 35 +++
 rtl/conv3x3_stream.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 streaming convolution block.
//   KSIZE / KTAPS   : kernel geometry (3x3, nine taps)
//   COEF_BIAS_ADDR  : coefficient address of the bias register (taps use 0..8)
//   DEF_*           : default parameter values for conv3x3_stream
package conv_pkg;

  localparam int KSIZE       = 3;
  localparam int KTAPS       = KSIZE * KSIZE;
  localparam int COEF_ADDR_W = 4;

  localparam logic [COEF_ADDR_W-1:0] COEF_BIAS_ADDR = 4'd9;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_OUT_W  = 9;
  localparam int DEF_IMG_W  = 4;
  localparam int DEF_IMG_H  = 4;

  // True when the address names a kernel tap or the bias register.
  function automatic logic coef_addr_ok(input logic [COEF_ADDR_W-1:0] addr);
    return (addr <= COEF_BIAS_ADDR);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Row delay line: a DEPTH-stage shift register advanced only when en is high.
// dout is the sample written DEPTH enabled cycles ago, i.e. the pixel directly
// above the incoming one when DEPTH equals the image width.
//   clk  : clock
//   en   : shift enable (one accepted pixel)
//   din  : incoming sample
//   dout : oldest stored sample
// Contents are pure data storage and are not reset.
module line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_DATA_W
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Shift the delay line by one position per enabled cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
      end
    end
  end

  assign dout = mem_r[DEPTH-1];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming valid-mode 3x3 correlation over a raster-ordered pixel stream.
//   coef_we/coef_addr/coef_data : kernel taps (0..8 row-major) and bias (9),
//                                 writable only while idle
//   relu_en                     : clamp negative results to zero
//   s_valid/s_ready/s_data      : pixel input handshake
//   m_valid/m_ready/m_data      : result output handshake, m_last on final result
//   busy                        : frame in progress or pipeline occupied
// Pipeline: S1 window register, S2 nine products, S3 sum/shift/saturate/ReLU.
// All stages advance together whenever the output register is free or drained.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     relu_en,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_data,
  output logic                     m_last,
  output logic                     busy
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + 4;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);

  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [COEF_W-1:0] coef_r [KTAPS];
  logic signed [COEF_W-1:0] bias_r;
  logic [CW-1:0]            col_r;
  logic [RW-1:0]            row_r;
  logic signed [DATA_W-1:0] win_r  [KTAPS];
  logic signed [PROD_W-1:0] prod_r [KTAPS];
  logic                     v1_r, v2_r, last1_r, last2_r;
  logic                     m_valid_r, m_last_r, busy_r;
  logic signed [OUT_W-1:0]  m_data_r;

  logic                     advance_s, accept_s, win_ok_s;
  logic                     col_last_s, row_last_s, frame_next_s;
  logic                     v1_next_s, v2_next_s, mv_next_s;
  logic [DATA_W-1:0]        lb0_dout_s, lb1_dout_s;
  logic signed [DATA_W-1:0] col_s [KSIZE];
  logic signed [ACC_W-1:0]  sum_s, shifted_s;
  logic signed [OUT_W-1:0]  sat_s, res_s;

  assign advance_s  = !m_valid_r || m_ready;
  assign accept_s   = s_valid && advance_s;
  assign col_last_s = (col_r == CW'(IMG_W - 1));
  assign row_last_s = (row_r == RW'(IMG_H - 1));
  assign win_ok_s   = accept_s && (row_r >= RW'(2)) && (col_r >= RW'(2) ? 1'b1 : 1'b0) && (col_r >= CW'(2));

  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
    .clk(clk), .en(accept_s), .din(s_data), .dout(lb0_dout_s)
  );
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
    .clk(clk), .en(accept_s), .din(lb0_dout_s), .dout(lb1_dout_s)
  );

  // Column entering the window: oldest row on top, live pixel at the bottom.
  assign col_s[0] = lb1_dout_s;
  assign col_s[1] = lb0_dout_s;
  assign col_s[2] = s_data;

  // Kernel and bias registers, frozen while a frame or its results are in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KTAPS; k++) coef_r[k] <= {COEF_W{1'b0}};
      bias_r <= {COEF_W{1'b0}};
    end else if (coef_we && !busy_r && coef_addr_ok(coef_addr)) begin
      if (coef_addr == COEF_BIAS_ADDR) bias_r <= coef_data;
      else                             coef_r[coef_addr] <= coef_data;
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (accept_s) begin
      if (col_last_s) begin
        col_r <= {CW{1'b0}};
        row_r <= row_last_s ? {RW{1'b0}} : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Next-state of the stage valids and of the frame-in-progress flag.
  always_comb begin
    if (advance_s) begin
      v1_next_s = win_ok_s;
      v2_next_s = v1_r;
      mv_next_s = v2_r;
    end else begin
      v1_next_s = v1_r;
      v2_next_s = v2_r;
      mv_next_s = m_valid_r;
    end
    if (accept_s) frame_next_s = !(row_last_s && col_last_s);
    else          frame_next_s = (col_r != {CW{1'b0}}) || (row_r != {RW{1'b0}});
  end

  // S1: slide the 3x3 window one column per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KTAPS; k++) win_r[k] <= {DATA_W{1'b0}};
      last1_r <= 1'b0;
    end else if (accept_s) begin
      for (int r = 0; r < KSIZE; r++) begin
        win_r[r*KSIZE]     <= win_r[r*KSIZE + 1];
        win_r[r*KSIZE + 1] <= win_r[r*KSIZE + 2];
        win_r[r*KSIZE + 2] <= col_s[r];
      end
      last1_r <= row_last_s && col_last_s;
    end
  end

  // S2: nine full-precision signed products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KTAPS; k++) prod_r[k] <= {PROD_W{1'b0}};
      last2_r <= 1'b0;
    end else if (advance_s) begin
      for (int k = 0; k < KTAPS; k++) begin
        prod_r[k] <= PROD_W'(win_r[k]) * PROD_W'(coef_r[k]);
      end
      last2_r <= last1_r;
    end
  end

  // S3 datapath: accumulate with bias, shift, saturate, optional ReLU.
  always_comb begin
    sum_s = ACC_W'(bias_r);
    for (int k = 0; k < KTAPS; k++) begin
      sum_s = sum_s + ACC_W'(prod_r[k]);
    end
    shifted_s = sum_s >>> SHIFT;
    if (shifted_s > OUT_MAX)      sat_s = OUT_MAX[OUT_W-1:0];
    else if (shifted_s < OUT_MIN) sat_s = OUT_MIN[OUT_W-1:0];
    else                          sat_s = shifted_s[OUT_W-1:0];
    if (relu_en && sat_s[OUT_W-1]) res_s = {OUT_W{1'b0}};
    else                           res_s = sat_s;
  end

  // Stage valids, output register and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_data_r  <= {OUT_W{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      v1_r      <= v1_next_s;
      v2_r      <= v2_next_s;
      m_valid_r <= mv_next_s;
      busy_r    <= frame_next_s || v1_next_s || v2_next_s || mv_next_s;
      if (advance_s) begin
        m_last_r <= v2_r && last2_r;
        if (v2_r) m_data_r <= res_s;
      end
    end
  end

  assign s_ready = advance_s;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign m_last  = m_last_r;
  assign busy    = busy_r;

endmodule
